multi_debouncer: RTL and testbench

//  Parametrised N-channel debouncer for the traffic-light push buttons and

---
 rtl/multi_debouncer.sv | 94 +++++++++
 tb/tb_multi_debouncer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// N-channel two-flop synchroniser + glitch filter with registered rise/fall pulses.
// Optional long-press detection is built when MULTI_DEBOUNCER_LONG_EN is defined.
module multi_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int RESET_LEVEL   = 0,
  parameter int LONG_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long
);

  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC = (RESET_LEVEL != 0) ? '1 : '0;

  logic [CHANNELS-1:0]            s1;
  logic [CHANNELS-1:0]            s2;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt;
  logic [CHANNELS-1:0]            commit;

  // A channel commits when its synchronised level has disagreed with clean long enough.
  always_comb begin
    commit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      commit[i] = (s2[i] != clean[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // NOTE: every register here is updated with <= so all channels see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= RST_VEC;
      s2    <= RST_VEC;
      clean <= RST_VEC;
      cnt   <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      s1   <= noisy;
      s2   <= s1;
      rise <= commit & s2;
      fall <= commit & ~s2;
      for (int i = 0; i < CHANNELS; i++) begin
        if (s2[i] == clean[i] || commit[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (commit[i]) begin
          clean[i] <= s2[i];
        end
      end
    end
  end

`ifdef MULTI_DEBOUNCER_LONG_EN
  localparam logic [CNT_W-1:0] HOLD_MAX     = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_FIRE    = CNT_W'((LONG_CYCLES > 1) ? LONG_CYCLES - 2 : 0);
  localparam logic             LONG_AT_RISE = (LONG_CYCLES == 1);

  logic [CHANNELS-1:0][CNT_W-1:0] hcnt;

  // hcnt is one less than the number of cycles clean has been high; it saturates
  // so that a held button produces exactly one long pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      long <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!clean[i]) begin
          hcnt[i] <= '0;
        end else if (hcnt[i] != HOLD_MAX) begin
          hcnt[i] <= hcnt[i] + 1'b1;
        end
        if (LONG_AT_RISE) begin
          long[i] <= commit[i] & s2[i];
        end else begin
          long[i] <= clean[i] && (hcnt[i] == HOLD_FIRE);
        end
      end
    end
  end
`else
  assign long = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: a window-based reference model predicts every
// cycle's clean/rise/fall/long, and a monitor compares one cycle after each rising edge.
module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int S  = 4;
  localparam int RL = 0;
  localparam int LC = 16;
`ifdef MULTI_DEBOUNCER_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam logic [CH-1:0] RLV = (RL != 0) ? 4'hF : 4'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] noisy = '0;
  logic [CH-1:0] clean, rise, fall, long;

  multi_debouncer #(
    .CHANNELS(CH), .STABLE_CYCLES(S), .CNT_W(8), .RESET_LEVEL(RL), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .noisy(noisy),
    .clean(clean), .rise(rise), .fall(fall), .long(long)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] long;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int rise_seen[CH];
  int fall_seen[CH];
  int long_seen[CH];

  // Reference state: per-edge history of sampled inputs, expected clean level, high-run length.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_clean;
  int            run[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the outputs after the following rising edge.
  // clean flips at an edge when the S inputs sampled 2..S+1 edges earlier all disagree with it.
  task automatic step(input logic [CH-1:0] n, input logic r);
    exp_t          e;
    logic [CH-1:0] nc;
    @(negedge clk);
    noisy = n;
    reset = r;
    e = '0;
    if (r) begin
      hist.delete();
      for (int k = 0; k < S + 2; k++) hist.push_back(RLV);
      m_clean = RLV;
      for (int c = 0; c < CH; c++) run[c] = RLV[c] ? 1 : 0;
      e.clean = RLV;
    end else begin
      hist.push_back(n);
      nc = m_clean;
      for (int c = 0; c < CH; c++) begin
        bit all_diff = 1'b1;
        for (int j = 0; j < S; j++) begin
          if (hist[hist.size() - 3 - j][c] == m_clean[c]) all_diff = 1'b0;
        end
        if (all_diff) nc[c] = ~m_clean[c];
        if (nc[c]) begin
          if (run[c] <= LC) run[c]++;
        end else begin
          run[c] = 0;
        end
        e.long[c] = LONG_EN && nc[c] && (run[c] == LC);
      end
      e.rise  = nc & ~m_clean;
      e.fall  = ~nc & m_clean;
      e.clean = nc;
      m_clean = nc;
      if (hist.size() > S + 4) void'(hist.pop_front());
    end
    sb.push_back(e);
  endtask

  task automatic hold(input logic [CH-1:0] n, input int cycles);
    for (int k = 0; k < cycles; k++) step(n, 1'b0);
  endtask

  // Monitor: compares every cycle that has a pending prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("clean", 32'(clean), 32'(e.clean));
      check("rise", 32'(rise), 32'(e.rise));
      check("fall", 32'(fall), 32'(e.fall));
      check("long", 32'(long), 32'(e.long));
      check("rise_fall_exclusive", 32'(rise & fall), 32'h0);
      for (int c = 0; c < CH; c++) begin
        rise_seen[c] += int'(rise[c]);
        fall_seen[c] += int'(fall[c]);
        long_seen[c] += int'(long[c]);
      end
    end
  end

  initial begin
    int r0, f0, l0;
    logic [CH-1:0] n;
    for (int c = 0; c < CH; c++) begin
      rise_seen[c] = 0; fall_seen[c] = 0; long_seen[c] = 0;
    end

    // Reset with all inputs high, then release with inputs low.
    repeat (5) step(4'hF, 1'b1);
    hold(4'h0, 10);

    // Clean step on channel 0.
    r0 = rise_seen[0];
    hold(4'h1, 10);
    check("step_rise0_count", 32'(rise_seen[0] - r0), 32'd1);

    // Glitch of 3 cycles rejected, then a 4-cycle pulse accepted on channel 1.
    r0 = rise_seen[1];
    hold(4'h3, 3);
    hold(4'h1, 10);
    check("glitch_rise1_count", 32'(rise_seen[1] - r0), 32'd0);
    hold(4'h3, 4);
    hold(4'h1, 12);
    check("pulse4_rise1_count", 32'(rise_seen[1] - r0), 32'd1);

    // Bounce on channel 2, long hold, release.
    r0 = rise_seen[2];
    f0 = fall_seen[2];
    hold(4'h5, 1); hold(4'h1, 1); hold(4'h5, 1); hold(4'h1, 1);
    hold(4'h5, 20);
    hold(4'h1, 12);
    check("bounce_rise2_count", 32'(rise_seen[2] - r0), 32'd1);
    check("bounce_fall2_count", 32'(fall_seen[2] - f0), 32'd1);

    // Simultaneous switching, then reset in the middle of a count.
    hold(4'h0, 12);
    hold(4'hF, 10);
    hold(4'h0, 3);
    step(4'h0, 1'b1);
    hold(4'h0, 10);

    // Long press and short press on channel 3.
    l0 = long_seen[3];
    hold(4'h8, 40);
    hold(4'h0, 12);
    check("long_press_count", 32'(long_seen[3] - l0), LONG_EN ? 32'd1 : 32'd0);
    l0 = long_seen[3];
    hold(4'h8, 10);
    hold(4'h0, 12);
    check("short_press_long_count", 32'(long_seen[3] - l0), 32'd0);

    // Randomised bouncing with occasional resets.
    n = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0) n[c] = ~n[c];
      end
      step(n, $urandom_range(149) == 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
